mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: the fetch stage (read-only) and the memory-access stage (read/write).
- Lets a unified instruction/data memory replace the separate instruction and main memory interfaces on the CPU top.
- Grants at most one access per cycle and tracks outstanding reads, so read data returns to the correct requester after a fixed memory latency.
- A non-granted requester stalls.

Parameters:
- ADDR_W, 32, address width.
- DAT_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (legal values 1..4).
- STARVE_MAX, 4, number of consecutive denied fetch cycles after which fetch wins arbitration (legal values 1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  active-low reset.
- if_req  in  1  fetch request (read).
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdat  out  DAT_W  fetch read data.
- ma_req  in  1  memory-access request.
- ma_wen  in  1  memory-access write enable.
- ma_addr  in  ADDR_W  memory-access address.
- ma_wdat  in  DAT_W  memory-access write data.
- ma_gnt  out  1  memory-access granted this cycle.
- ma_rvalid  out  1  memory-access read data valid.
- ma_rdat  out  DAT_W  memory-access read data.
- mem_cs  out  1  memory chip-select.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_dat_in  out  DAT_W  write data (from memory point of view).
- mem_dat_out  in  DAT_W  read data (from memory point of view).

Behaviour:
- Single clock, clk. Reset is synchronous, active-low (rst_n sampled on posedge clk).
- Grant is combinational, decided in the same cycle as the request:
  - only one requester: it is granted;
  - both requesting: ma wins, unless starve_cnt == STARVE_MAX, in which case if wins.
- Grants are one-hot or zero: never if_gnt & ma_gnt.
- Memory drive:
  - mem_cs = if_gnt | ma_gnt;
  - mem_wen = ma_gnt & ma_wen;
  - mem_addr and mem_dat_in are muxed from the granted port;
  - with no grant, mem_addr and mem_dat_in are 0.
- Requester rule: req, addr, wen and wdat are held stable until gnt is seen. The bench checks this; the RTL does not.
- Starvation counter, starve_cnt (4 bits):
  - increments when if_req & !if_gnt, saturating at STARVE_MAX;
  - clears on if_gnt or !if_req;
  - reset value 0.
- Read-return tag pipeline, MEM_LAT stages, each entry {valid, port}:
  - stage 0 loads valid = mem_cs & !mem_wen, with port = IF or MA;
  - it shifts every cycle with no stall, because memory latency is fixed.
- Final stage output:
  - if_rvalid = valid & port==IF;
  - ma_rvalid = valid & port==MA;
  - if_rdat = ma_rdat = mem_dat_out, driven unqualified; consumers qualify with rvalid.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. With MEM_LAT up to 4, up to MEM_LAT reads are in flight; tags preserve order.
- Reset values:
  - all tag stages invalid, so if_rvalid = ma_rvalid = 0;
  - starve_cnt = 0;
  - combinational outputs follow inputs. While !rst_n, gnt and mem_cs are forced to 0.
- Reset mid-operation: in-flight reads are discarded and no rvalid appears after reset deasserts.
- Simultaneous grant and return in one cycle is legal and independent.

Decomposition:
- Package mem_port_arbiter_pkg:
  - typedef enum logic [1:0] {PORT_NONE, PORT_IF, PORT_MA} port_id_t;
  - typedef struct {logic vld; port_id_t port;} rd_tag_t;
  - localparam MAX_MEM_LAT = 4;
  - localparam STARVE_CNT_W = 4.
- One sub-module: rd_tag_pipe, a MEM_LAT-deep shift register of rd_tag_t with synchronous active-low clear.
- The arbitration, counter and muxing stay in the top.

Test Plan:
- ma_req=1 ma_wen=1 addr=0x10 wdat=0xDEADBEEF, if_req=0 -> ma_gnt=1, mem_wen=1, mem_addr=0x10, mem_dat_in=0xDEADBEEF; no rvalid afterwards.
- MEM_LAT=1, if_req=1 addr=0x10 alone -> if_gnt=1; next cycle if_rvalid=1, if_rdat=0xDEADBEEF, ma_rvalid=0.
- STARVE_MAX=4, ma_req and if_req held high with ma reads -> ma_gnt for 4 cycles, if_gnt on the 5th, then ma regains; pattern repeats every 5 cycles.
- MEM_LAT=3, alternating grants IF,MA,IF on addresses 0x0/0x4/0x8 preloaded 1/2/3 -> rvalid 3 cycles later in order: if=1, ma=2, if=3.
- Read granted, then rst_n=0 for 1 cycle before return -> no rvalid ever; starve_cnt=0; first post-reset cycle grants normally.
- Random if/ma traffic for 10k cycles -> grants never both high, every read returns exactly once to its requester after MEM_LAT, fetch wait never exceeds STARVE_MAX+1 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// The port id is carried by every read tag so returning data can be steered.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    PORT_NONE,
    PORT_IF,
    PORT_MA
  } port_id_t;

  typedef struct packed {
    logic     vld;
    port_id_t port;
  } rd_tag_t;

  localparam int MAX_MEM_LAT  = 4;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory-access requesters, the arbiter and the
// single-port memory. The arbiter takes the slave view; the environment the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DAT_W  = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DAT_W-1:0]  if_rdat;

  logic              ma_req;
  logic              ma_wen;
  logic [ADDR_W-1:0] ma_addr;
  logic [DAT_W-1:0]  ma_wdat;
  logic              ma_gnt;
  logic              ma_rvalid;
  logic [DAT_W-1:0]  ma_rdat;

  logic              mem_cs;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DAT_W-1:0]  mem_dat_in;
  logic [DAT_W-1:0]  mem_dat_out;

  modport slave (
    input  if_req, if_addr, ma_req, ma_wen, ma_addr, ma_wdat, mem_dat_out,
    output if_gnt, if_rvalid, if_rdat, ma_gnt, ma_rvalid, ma_rdat,
    output mem_cs, mem_wen, mem_addr, mem_dat_in
  );

  modport master (
    output if_req, if_addr, ma_req, ma_wen, ma_addr, ma_wdat, mem_dat_out,
    input  if_gnt, if_rvalid, if_rdat, ma_gnt, ma_rvalid, ma_rdat,
    input  mem_cs, mem_wen, mem_addr, mem_dat_in
  );

endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Fixed-latency shift register of read tags; it never stalls because the
// memory answers exactly DEPTH cycles after a read is issued.
module rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '{vld: 1'b0, port: PORT_NONE};
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (read-only) and
// memory-access (read/write); reads are tagged so data returns to its requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DAT_W      = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    if_gnt_c;
  logic                    ma_gnt_c;
  logic [ADDR_W-1:0]       addr_mux;
  logic [DAT_W-1:0]        wdat_mux;
  rd_tag_t                 tag_in;
  rd_tag_t                 tag_out;

  // Memory access normally wins a conflict; a fetch denied STARVE_MAX times in a row wins instead.
  always_comb begin
    if_gnt_c = 1'b0;
    ma_gnt_c = 1'b0;
    addr_mux = '0;
    wdat_mux = '0;
    if (rst_n) begin
      if (bus.if_req && bus.ma_req) begin
        if (starve_cnt == STARVE_LIM) begin
          if_gnt_c = 1'b1;
        end else begin
          ma_gnt_c = 1'b1;
        end
      end else begin
        if_gnt_c = bus.if_req;
        ma_gnt_c = bus.ma_req;
      end
    end
    if (if_gnt_c) begin
      addr_mux = bus.if_addr;
    end else if (ma_gnt_c) begin
      addr_mux = bus.ma_addr;
      wdat_mux = bus.ma_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || if_gnt_c) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
    end
  end

  assign bus.if_gnt     = if_gnt_c;
  assign bus.ma_gnt     = ma_gnt_c;
  assign bus.mem_cs     = if_gnt_c | ma_gnt_c;
  assign bus.mem_wen    = ma_gnt_c & bus.ma_wen;
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_dat_in = wdat_mux;

  always_comb begin
    tag_in.vld  = (if_gnt_c | ma_gnt_c) & ~(ma_gnt_c & bus.ma_wen);
    tag_in.port = if_gnt_c ? PORT_IF : (ma_gnt_c ? PORT_MA : PORT_NONE);
  end

  rd_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Reads still in flight when reset is applied must never surface as valid data.
  assign bus.if_rvalid = rst_n && tag_out.vld && (tag_out.port == PORT_IF);
  assign bus.ma_rvalid = rst_n && tag_out.vld && (tag_out.port == PORT_MA);
  assign bus.if_rdat   = bus.mem_dat_out;
  assign bus.ma_rdat   = bus.mem_dat_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queued requesters, a behavioural memory
// and a reference model of arbitration and read return order.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 4;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] dat;
  } cmd_t;

  typedef struct {
    int          due;
    bit          is_if;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_W(32), .DAT_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DAT_W      (32),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] if_cmd_q [$];
  cmd_t        ma_cmd_q [$];
  exp_t        sb_q [$];
  logic [31:0] ref_mem [16];
  logic [31:0] dev_mem [16];
  logic [31:0] dev_pipe [MEM_LAT];
  logic [31:0] if_cur;
  cmd_t        ma_cur;
  bit          if_busy = 0, ma_busy = 0, if_took = 0, ma_took = 0;
  int          model_wait = 0;
  int          dut_wait = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Requesters hold req/addr/wen/wdat until they have seen their grant.
  task automatic applyStimulus();
    if (if_took) if_busy = 0;
    if (ma_took) ma_busy = 0;
    if_took = 0;
    ma_took = 0;
    if (!if_busy && if_cmd_q.size() > 0) begin
      if_cur  = if_cmd_q.pop_front();
      if_busy = 1;
    end
    if (!ma_busy && ma_cmd_q.size() > 0) begin
      ma_cur  = ma_cmd_q.pop_front();
      ma_busy = 1;
    end
    bus.if_req  = if_busy;
    bus.if_addr = if_busy ? if_cur : $urandom;
    bus.ma_req  = ma_busy;
    bus.ma_wen  = ma_busy ? ma_cur.wen : 1'($urandom);
    bus.ma_addr = ma_busy ? ma_cur.addr : $urandom;
    bus.ma_wdat = ma_busy ? ma_cur.dat : $urandom;
  endtask

  task automatic pushIf(input logic [31:0] a);
    if_cmd_q.push_back(a);
  endtask

  task automatic pushMa(input bit w, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.wen  = w;
    c.addr = a;
    c.dat  = d;
    ma_cmd_q.push_back(c);
  endtask

  task automatic waitIdle(input int budget);
    int  n = 0;
    bit  busy;
    busy = (if_cmd_q.size() > 0) || (ma_cmd_q.size() > 0) || if_busy || ma_busy;
    while (busy && n < budget) begin
      @(posedge clk);
      n++;
      busy = (if_cmd_q.size() > 0) || (ma_cmd_q.size() > 0) || if_busy || ma_busy;
    end
    checkOutput("wait_idle", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] randAddr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    applyStimulus();
  end

  // Behavioural single-port memory with exactly MEM_LAT cycles of read latency.
  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) dev_pipe[i] <= dev_pipe[i-1];
    if (bus.mem_cs && !bus.mem_wen) dev_pipe[0] <= dev_mem[bus.mem_addr[5:2]];
    else                            dev_pipe[0] <= $urandom;
    if (bus.mem_cs && bus.mem_wen)  dev_mem[bus.mem_addr[5:2]] <= bus.mem_dat_in;
  end
  assign bus.mem_dat_out = dev_pipe[MEM_LAT-1];

  // Reference model: who should be granted, what the memory should see, what must come back.
  always @(negedge clk) begin
    bit          e_if, e_ma;
    logic [31:0] e_addr, e_din;
    exp_t        e;
    e_if = 0;
    e_ma = 0;
    if (rst_n) begin
      if (bus.if_req && bus.ma_req) begin
        e_if = (model_wait >= STARVE_MAX);
        e_ma = !e_if;
      end else begin
        e_if = bus.if_req;
        e_ma = bus.ma_req;
      end
    end
    e_addr = e_if ? bus.if_addr : (e_ma ? bus.ma_addr : 32'd0);
    e_din  = e_ma ? bus.ma_wdat : 32'd0;
    checkOutput("grant", 64'({bus.if_gnt, bus.ma_gnt}), 64'({e_if, e_ma}));
    checkOutput("mem_ctl", 64'({bus.mem_cs, bus.mem_wen}), 64'({e_if | e_ma, e_ma & bus.ma_wen}));
    checkOutput("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
    checkOutput("mem_dat_in", 64'(bus.mem_dat_in), 64'(e_din));

    if (e_if) begin
      e.due   = cyc + MEM_LAT;
      e.is_if = 1;
      e.data  = ref_mem[bus.if_addr[5:2]];
      sb_q.push_back(e);
      model_wait = 0;
    end else if (rst_n && bus.if_req) begin
      model_wait++;
    end else begin
      model_wait = 0;
    end

    if (e_ma) begin
      if (bus.ma_wen) begin
        ref_mem[bus.ma_addr[5:2]] = bus.ma_wdat;
      end else begin
        e.due   = cyc + MEM_LAT;
        e.is_if = 0;
        e.data  = ref_mem[bus.ma_addr[5:2]];
        sb_q.push_back(e);
      end
    end

    if (rst_n && bus.if_req && bus.if_gnt) begin
      checkOutput("fetch_wait", 64'(dut_wait + 1 <= STARVE_MAX + 1), 64'd1);
      dut_wait = 0;
    end else if (rst_n && bus.if_req) begin
      dut_wait++;
    end else begin
      dut_wait = 0;
    end

    if_took = bus.if_gnt;
    ma_took = bus.ma_gnt;
  end

  // Monitor: every cycle, compare rvalids with the head of the scoreboard.
  always @(negedge clk) begin
    exp_t h;
    bit   exp_v;
    if (!rst_n) begin
      checkOutput("rvalid_in_reset", 64'({bus.if_rvalid, bus.ma_rvalid}), 64'd0);
      sb_q.delete();
    end else begin
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        h = sb_q.pop_front();
        checkOutput("missed_return", 64'(h.due), 64'(cyc));
      end
      exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      if (exp_v) begin
        h = sb_q.pop_front();
        checkOutput("rvalid", 64'({bus.if_rvalid, bus.ma_rvalid}), 64'({h.is_if, !h.is_if}));
        checkOutput("rdat", 64'(h.is_if ? bus.if_rdat : bus.ma_rdat), 64'(h.data));
      end else if (bus.if_rvalid || bus.ma_rvalid) begin
        checkOutput("rvalid", 64'({bus.if_rvalid, bus.ma_rvalid}), 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h0101_0101 * 32'(i);
      dev_mem[i] = 32'h0101_0101 * 32'(i);
    end
    for (int i = 0; i < MEM_LAT; i++) dev_pipe[i] = 32'd0;
    rst_n       = 1'b0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.ma_req  = 1'b0;
    bus.ma_wen  = 1'b0;
    bus.ma_addr = '0;
    bus.ma_wdat = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] write then fetch-read of 0x10");
    @(posedge clk);
    pushMa(1, 32'h10, 32'hDEAD_BEEF);
    waitIdle(20);
    pushIf(32'h10);
    waitIdle(20);
    repeat (MEM_LAT + 2) @(posedge clk);

    $display("[TB] fetch starvation under continuous ma reads");
    @(posedge clk);
    for (int i = 0; i < 12; i++) pushMa(0, randAddr(), 32'd0);
    pushIf(32'h20);
    pushIf(32'h24);
    waitIdle(60);

    $display("[TB] interleaved IF/MA/IF reads of preloaded words");
    pushMa(1, 32'h0, 32'd1);
    pushMa(1, 32'h4, 32'd2);
    pushMa(1, 32'h8, 32'd3);
    waitIdle(20);
    @(posedge clk) pushIf(32'h0);
    @(posedge clk) pushMa(0, 32'h4, 32'd0);
    @(posedge clk) pushIf(32'h8);
    waitIdle(20);
    repeat (MEM_LAT + 2) @(posedge clk);

    $display("[TB] reset with reads in flight");
    @(posedge clk);
    pushIf(32'h4);
    pushMa(0, 32'h8, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitIdle(20);
    repeat (MEM_LAT + 2) @(posedge clk);

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      if (if_cmd_q.size() < 2 && $urandom_range(0, 99) < 60) pushIf(randAddr());
      if (ma_cmd_q.size() < 2 && $urandom_range(0, 99) < 55)
        pushMa(1'($urandom), randAddr(), $urandom);
      #1 rst_n = !((i % 2500) == 1250);
    end
    #1 rst_n = 1'b1;
    waitIdle(100);
    repeat (MEM_LAT + 3) @(posedge clk);
    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
